// File: rtl/alu_mc_if.sv
// ============================================================================
// Module   : alu_mc_if
// Brief    : Command/result bundle between the SAP-1 controller and alu_mc.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_mc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int RS_W       = $clog2(NUM_REGS)
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [3:0]            opcode;
    logic [RS_W-1:0]       reg_sel;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_valid;
    logic                  busy;
    logic                  flag_carry;
    logic                  flag_zero;
    logic                  flag_neg;

    modport master (
        output cmd_valid, opcode, reg_sel, data_in,
        input  cmd_ready, data_out, out_valid, busy,
               flag_carry, flag_zero, flag_neg
    );

    modport slave (
        input  cmd_valid, opcode, reg_sel, data_in,
        output cmd_ready, data_out, out_valid, busy,
               flag_carry, flag_zero, flag_neg
    );
endinterface

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
// Module   : alu_mc
// Brief    : Multi-cycle accumulator ALU with register file, carry-chained
//            arithmetic and an iterative shift-and-add multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int RS_W       = $clog2(NUM_REGS)
) (
    input  wire logic  clk,
    input  wire logic  a_reset_n,
    alu_mc_if.slave    bus
);

    localparam int CNT_W  = $clog2(DATA_WIDTH);
    localparam int PROD_W = 2 * DATA_WIDTH;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_MULT = 1'b1;

    localparam logic [3:0] c_OP_NOP  = 4'd0;
    localparam logic [3:0] c_OP_LDR  = 4'd1;
    localparam logic [3:0] c_OP_LDA  = 4'd2;
    localparam logic [3:0] c_OP_ADD  = 4'd3;
    localparam logic [3:0] c_OP_ADC  = 4'd4;
    localparam logic [3:0] c_OP_SUB  = 4'd5;
    localparam logic [3:0] c_OP_AND  = 4'd6;
    localparam logic [3:0] c_OP_OR   = 4'd7;
    localparam logic [3:0] c_OP_XOR  = 4'd8;
    localparam logic [3:0] c_OP_SHL  = 4'd9;
    localparam logic [3:0] c_OP_SHR  = 4'd10;
    localparam logic [3:0] c_OP_MUL  = 4'd11;
    localparam logic [3:0] c_OP_OUT  = 4'd12;
    localparam logic [3:0] c_OP_CLR  = 4'd13;
    localparam logic [3:0] c_OP_STA  = 4'd14;
    localparam logic [3:0] c_OP_RSVD = 4'd15;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [0:0]            w_state_next;

    logic [DATA_WIDTH-1:0] r_acc;
    logic                  r_carry;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_out_valid;

    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [PROD_W-1:0]     r_prod;
    logic [CNT_W-1:0]      r_cnt;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                  w_busy;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_mul_start;
    logic                  w_mul_last;
    logic [DATA_WIDTH-1:0] w_operand;
    logic [DATA_WIDTH:0]   w_add;
    logic [DATA_WIDTH:0]   w_adc;
    logic [DATA_WIDTH:0]   w_sub;
    logic [PROD_W-1:0]     w_addend;
    logic [PROD_W-1:0]     w_prod_next;

    logic [DATA_WIDTH-1:0] w_acc_next;
    logic                  w_carry_next;
    logic                  w_reg_we;
    logic [DATA_WIDTH-1:0] w_reg_wdata;
    logic                  w_out_load;
    logic [NUM_REGS-1:0]   w_reg_hit;

    assign w_accept    = bus.cmd_valid && w_ready;
    assign w_mul_start = w_accept && (bus.opcode == c_OP_MUL);
    assign w_mul_last  = (r_state == c_ST_MULT) && (r_cnt == c_CNT_LAST);
    assign w_operand   = r_regs[bus.reg_sel];

    // One extra bit on every arithmetic result carries the carry/borrow out.
    assign w_add = {1'b0, r_acc} + {1'b0, w_operand};
    assign w_adc = w_add + {{DATA_WIDTH{1'b0}}, r_carry};
    assign w_sub = {1'b0, r_acc} - {1'b0, w_operand};

    assign w_addend    = r_mplier[0] ? ({{DATA_WIDTH{1'b0}}, r_mcand} << r_cnt)
                                     : '0;
    assign w_prod_next = r_prod + w_addend;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_mul_start) w_state_next = c_ST_MULT;
            c_ST_MULT: if (w_mul_last)  w_state_next = c_ST_IDLE;
            default:                    w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy  = (r_state == c_ST_MULT);
        w_ready = !w_busy;
    end

    // ------------------------------------------------------------------------
    // Accumulator, carry and register-file update selection
    // ------------------------------------------------------------------------
    always_comb begin
        w_acc_next   = r_acc;
        w_carry_next = r_carry;
        w_reg_we     = 1'b0;
        w_reg_wdata  = bus.data_in;
        w_out_load   = 1'b0;

        if (w_mul_last) begin
            // Overflow is any set bit in the upper half of the product.
            w_acc_next   = w_prod_next[DATA_WIDTH-1:0];
            w_carry_next = |w_prod_next[PROD_W-1:DATA_WIDTH];
        end else if (w_accept) begin
            case (bus.opcode)
                c_OP_NOP, c_OP_RSVD, c_OP_MUL: begin
                end
                c_OP_LDR: begin
                    w_reg_we    = 1'b1;
                    w_reg_wdata = bus.data_in;
                end
                c_OP_LDA: w_acc_next = bus.data_in;
                c_OP_ADD: begin
                    w_acc_next   = w_add[DATA_WIDTH-1:0];
                    w_carry_next = w_add[DATA_WIDTH];
                end
                c_OP_ADC: begin
                    w_acc_next   = w_adc[DATA_WIDTH-1:0];
                    w_carry_next = w_adc[DATA_WIDTH];
                end
                c_OP_SUB: begin
                    w_acc_next   = w_sub[DATA_WIDTH-1:0];
                    w_carry_next = w_sub[DATA_WIDTH];
                end
                c_OP_AND: begin
                    w_acc_next   = r_acc & w_operand;
                    w_carry_next = 1'b0;
                end
                c_OP_OR: begin
                    w_acc_next   = r_acc | w_operand;
                    w_carry_next = 1'b0;
                end
                c_OP_XOR: begin
                    w_acc_next   = r_acc ^ w_operand;
                    w_carry_next = 1'b0;
                end
                c_OP_SHL: begin
                    w_acc_next   = {r_acc[DATA_WIDTH-2:0], 1'b0};
                    w_carry_next = r_acc[DATA_WIDTH-1];
                end
                c_OP_SHR: begin
                    w_acc_next   = {1'b0, r_acc[DATA_WIDTH-1:1]};
                    w_carry_next = r_acc[0];
                end
                c_OP_OUT: w_out_load = 1'b1;
                c_OP_CLR: begin
                    w_acc_next   = '0;
                    w_carry_next = 1'b0;
                end
                c_OP_STA: begin
                    w_reg_we    = 1'b1;
                    w_reg_wdata = r_acc;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Register-file write decode
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_hit
        assign w_reg_hit[gi] = w_reg_we && (bus.reg_sel == RS_W'(gi));
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_reg_hit[i]) begin
                    r_regs[i] <= w_reg_wdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator, flags and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_acc       <= w_acc_next;
            r_carry     <= w_carry_next;
            r_out_valid <= w_out_load;
            if (w_out_load) begin
                r_data_out <= r_acc;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Shift-and-add multiplier: one multiplier bit per cycle, LSB first
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (w_mul_start) begin
            r_mcand  <= r_acc;
            r_mplier <= w_operand;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (r_state == c_ST_MULT) begin
            r_prod   <= w_prod_next;
            r_mplier <= {1'b0, r_mplier[DATA_WIDTH-1:1]};
            r_cnt    <= w_mul_last ? '0 : r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.cmd_ready  = w_ready;
    assign bus.busy       = w_busy;
    assign bus.data_out   = r_data_out;
    assign bus.out_valid  = r_out_valid;
    assign bus.flag_carry = r_carry;
    assign bus.flag_zero  = (r_acc == '0);
    assign bus.flag_neg   = r_acc[DATA_WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
// Module   : tb_alu_mc
// Brief    : Self-checking bench for alu_mc: directed scenarios plus random
//            commands against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mc;

    localparam int W    = 8;
    localparam int NR   = 4;
    localparam int MASK = (1 << W) - 1;

    localparam int OP_NOP = 0,  OP_LDR = 1,  OP_LDA = 2,  OP_ADD = 3;
    localparam int OP_ADC = 4,  OP_SUB = 5,  OP_AND = 6,  OP_OR  = 7;
    localparam int OP_XOR = 8,  OP_SHL = 9,  OP_SHR = 10, OP_MUL = 11;
    localparam int OP_OUT = 12, OP_CLR = 13, OP_STA = 14, OP_RSV = 15;

    logic clk = 1'b0;
    logic a_reset_n = 1'b0;

    always #5 clk = ~clk;

    alu_mc_if #(.DATA_WIDTH(W), .NUM_REGS(NR)) bus ();

    alu_mc #(.DATA_WIDTH(W), .NUM_REGS(NR)) dut (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .bus       (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int unsigned m_acc;
    int unsigned m_carry;
    int unsigned m_regs [NR];
    int unsigned m_out;
    int unsigned m_outv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_carry = 0; m_out = 0; m_outv = 0;
        for (int i = 0; i < NR; i++) m_regs[i] = 0;
    endtask

    task automatic model_apply(input int op, input int rs, input int din);
        int unsigned r, s;
        longint unsigned p;
        r = m_regs[rs];
        m_outv = 0;
        case (op)
            OP_LDR: m_regs[rs] = din;
            OP_LDA: m_acc = din;
            OP_ADD: begin s = m_acc + r;           m_carry = s >> W; m_acc = s & MASK; end
            OP_ADC: begin s = m_acc + r + m_carry; m_carry = s >> W; m_acc = s & MASK; end
            OP_SUB: begin m_carry = (m_acc < r) ? 1 : 0; m_acc = (m_acc - r) & MASK; end
            OP_AND: begin m_acc = m_acc & r; m_carry = 0; end
            OP_OR:  begin m_acc = m_acc | r; m_carry = 0; end
            OP_XOR: begin m_acc = m_acc ^ r; m_carry = 0; end
            OP_SHL: begin m_carry = (m_acc >> (W - 1)) & 1; m_acc = (m_acc << 1) & MASK; end
            OP_SHR: begin m_carry = m_acc & 1; m_acc = m_acc >> 1; end
            OP_MUL: begin
                p = longint'(m_acc) * longint'(r);
                m_acc   = int'(p & MASK);
                m_carry = ((p >> W) != 0) ? 1 : 0;
            end
            OP_OUT: begin m_out = m_acc; m_outv = 1; end
            OP_CLR: begin m_acc = 0; m_carry = 0; end
            OP_STA: m_regs[rs] = m_acc;
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".carry"},     32'(bus.flag_carry), m_carry);
        check({tag, ".zero"},      32'(bus.flag_zero),  (m_acc == 0) ? 1 : 0);
        check({tag, ".neg"},       32'(bus.flag_neg),   (m_acc >> (W - 1)) & 1);
        check({tag, ".ready"},     32'(bus.cmd_ready),  1);
        check({tag, ".busy"},      32'(bus.busy),       0);
        check({tag, ".out_valid"}, 32'(bus.out_valid),  m_outv);
        check({tag, ".data_out"},  32'(bus.data_out),   m_out);
    endtask

    // Called at a falling edge; returns at the falling edge where the result is visible.
    task automatic do_cmd(input int op, input int rs, input int din);
        int waited = 0;
        bus.cmd_valid = 1'b1;
        bus.opcode    = 4'(op);
        bus.reg_sel   = 2'(rs);
        bus.data_in   = 8'(din);
        while (!bus.cmd_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.cmd_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        model_apply(op, rs, din);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.opcode    = 4'd0;
        if (op == OP_MUL) begin
            for (int i = 0; i < W; i++) begin
                check("mul_busy",  32'(bus.busy),      1);
                check("mul_ready", 32'(bus.cmd_ready), 0);
                @(negedge clk);
            end
        end
        check_outputs($sformatf("op%0d", op));
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.opcode    = 4'd0;
        bus.reg_sel   = 2'd0;
        bus.data_in   = 8'd0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs("reset");
        a_reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_out_valid", 32'(bus.out_valid), 0);
        end

        // Carry chaining
        do_cmd(OP_LDA, 0, 'hF0);
        do_cmd(OP_LDR, 1, 'h20);
        do_cmd(OP_ADD, 1, 0);
        check("add_carry", 32'(bus.flag_carry), 1);
        check("add_zero",  32'(bus.flag_zero),  0);
        do_cmd(OP_ADC, 1, 0);
        check("adc_carry", 32'(bus.flag_carry), 0);
        do_cmd(OP_OUT, 0, 0);
        check("adc_acc", 32'(bus.data_out), 'h31);

        // Borrow
        do_cmd(OP_LDA, 0, 'h05);
        do_cmd(OP_LDR, 2, 'h06);
        do_cmd(OP_SUB, 2, 0);
        check("sub_borrow", 32'(bus.flag_carry), 1);
        check("sub_neg",    32'(bus.flag_neg),   1);
        do_cmd(OP_AND, 2, 0);
        do_cmd(OP_OUT, 0, 0);
        check("and_acc", 32'(bus.data_out), 'h06);

        // MUL with a following LDA held across the busy window
        do_cmd(OP_LDA, 0, 'h0D);
        do_cmd(OP_LDR, 3, 'h0B);
        bus.cmd_valid = 1'b1;
        bus.opcode    = 4'(OP_MUL);
        bus.reg_sel   = 2'd3;
        @(posedge clk);
        model_apply(OP_MUL, 3, 0);
        @(negedge clk);
        bus.opcode  = 4'(OP_LDA);
        bus.data_in = 8'h55;
        for (int i = 0; i < W; i++) begin
            check("hold_busy", 32'(bus.busy), 1);
            @(negedge clk);
        end
        check("mul_done_busy", 32'(bus.busy),       0);
        check("mul_carry",     32'(bus.flag_carry), 0);
        check("mul_neg",       32'(bus.flag_neg),   1);
        @(posedge clk);
        model_apply(OP_LDA, 0, 'h55);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check_outputs("held_lda");
        do_cmd(OP_OUT, 0, 0);
        check("held_lda_acc", 32'(bus.data_out), 'h55);

        do_cmd(OP_LDA, 0, 'h0D);
        do_cmd(OP_MUL, 3, 0);
        do_cmd(OP_OUT, 0, 0);
        check("mul_acc", 32'(bus.data_out), 'h8F);

        do_cmd(OP_LDA, 0, 'h20);
        do_cmd(OP_LDR, 1, 'h10);
        do_cmd(OP_MUL, 1, 0);
        check("mul_ovf_carry", 32'(bus.flag_carry), 1);
        check("mul_ovf_zero",  32'(bus.flag_zero),  1);

        // Shifts, output pulse, store
        do_cmd(OP_LDA, 0, 'h81);
        do_cmd(OP_SHL, 0, 0);
        check("shl_carry", 32'(bus.flag_carry), 1);
        do_cmd(OP_SHR, 0, 0);
        check("shr_carry", 32'(bus.flag_carry), 0);
        do_cmd(OP_OUT, 0, 0);
        check("out_data",  32'(bus.data_out),  'h01);
        check("out_pulse", 32'(bus.out_valid), 1);
        do_cmd(OP_STA, 0, 0);
        check("out_pulse_end", 32'(bus.out_valid), 0);
        do_cmd(OP_LDA, 0, 'h00);
        do_cmd(OP_OR, 0, 0);
        do_cmd(OP_OUT, 0, 0);
        check("sta_or_acc", 32'(bus.data_out), 'h01);

        // Reset in the middle of a MUL
        do_cmd(OP_LDA, 0, 'h37);
        do_cmd(OP_LDR, 2, 'h05);
        bus.cmd_valid = 1'b1;
        bus.opcode    = 4'(OP_MUL);
        bus.reg_sel   = 2'd2;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        a_reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_busy",  32'(bus.busy),       0);
        check("rst_ready", 32'(bus.cmd_ready),  1);
        check("rst_zero",  32'(bus.flag_zero),  1);
        check("rst_carry", 32'(bus.flag_carry), 0);
        @(negedge clk);
        a_reset_n = 1'b1;
        @(negedge clk);
        do_cmd(OP_NOP, 1, 'hAA);
        do_cmd(OP_RSV, 2, 'h5A);
        do_cmd(OP_OUT, 0, 0);
        check("post_rst_acc", 32'(bus.data_out), 0);
        do_cmd(OP_LDA, 0, 0);
        do_cmd(OP_OR, 2, 0);
        do_cmd(OP_OUT, 0, 0);
        check("post_rst_reg", 32'(bus.data_out), 0);

        // Random commands against the model
        for (int n = 0; n < 300; n++) begin
            do_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, NR - 1)),
                   int'($urandom_range(0, MASK)));
            if (n % 8 == 7) do_cmd(OP_OUT, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
